// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side round-robin arbiter.
// Holds the FSM encoding and the tag-width helper.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // A two-producer configuration still needs a one-bit tag.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pri_enc.sv
// Rotating priority encoder: returns the first set request after lptr,
// wrapping explicitly so non-power-of-two request counts work.
module rr_pri_enc #(
    parameter int P_N    = 4,
    parameter int P_ID_W = 2
) (
    input  logic [P_N-1:0]    req,
    input  logic [P_ID_W-1:0] lptr,
    output logic              found,
    output logic [P_ID_W-1:0] cand
);

    logic [P_ID_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = lptr;
        for (int off = 0; off < P_N; off++) begin
            idx = (idx == P_ID_W'(P_N - 1)) ? '0 : idx + P_ID_W'(1);
            if (!found && req[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rr_arb.sv
// Round-robin arbiter sharing one FIFO write port among producers, granting
// bursts of up to P_BURST beats and tagging each word with its source ID.
module fifo_wr_rr_arb
    import fifo_arb_pkg::*;
#(
    parameter int P_NUM_REQ = 4,
    parameter int P_DATA_W  = 8,
    parameter int P_BURST   = 4,
    localparam int P_ID_W   = id_width(P_NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [P_NUM_REQ-1:0]          i_req_valid,
    input  logic [P_NUM_REQ*P_DATA_W-1:0] i_req_data,
    output logic [P_NUM_REQ-1:0]          o_req_ready,
    output logic                          o_fifo_wr_en,
    output logic [P_ID_W+P_DATA_W-1:0]    o_fifo_data,
    input  logic                          i_fifo_full,
    output logic                          o_busy
);

    localparam int CNT_W = $clog2(P_BURST + 1);

    arb_state_e        state, state_n;
    logic [P_ID_W-1:0] owner, owner_n;
    logic [P_ID_W-1:0] lptr, lptr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              found;
    logic [P_ID_W-1:0] cand;
    logic [P_ID_W-1:0] sel;
    logic              xfer;

    rr_pri_enc #(
        .P_N    (P_NUM_REQ),
        .P_ID_W (P_ID_W)
    ) u_pri_enc (
        .req   (i_req_valid),
        .lptr  (lptr),
        .found (found),
        .cand  (cand)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= '0;
            lptr  <= P_ID_W'(P_NUM_REQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            lptr  <= lptr_n;
            cnt   <= cnt_n;
        end
    end

    // Leaving BURST needs no pointer update: lptr already equals the owner,
    // so the released producer drops to lowest priority.
    always_comb begin
        state_n = state;
        owner_n = owner;
        lptr_n  = lptr;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    owner_n = cand;
                    lptr_n  = cand;
                    if (P_BURST > 1) begin
                        cnt_n   = CNT_W'(1);
                        state_n = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    if (int'(cnt) + 1 == P_BURST) begin
                        cnt_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (!i_req_valid[owner]) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        o_busy      = 1'b0;
        sel         = (state == ST_BURST) ? owner : cand;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (found && !i_fifo_full) o_req_ready[cand] = 1'b1;
                end
                ST_BURST: begin
                    o_busy = 1'b1;
                    if (i_req_valid[owner] && !i_fifo_full) o_req_ready[owner] = 1'b1;
                end
                default: ;
            endcase
        end
        xfer         = |o_req_ready;
        o_fifo_wr_en = xfer;
        o_fifo_data  = xfer ? {sel, i_req_data[int'(sel)*P_DATA_W +: P_DATA_W]} : '0;
    end

endmodule

// File: tb/tb_fifo_wr_rr_arb.sv
// Directed bench for fifo_wr_rr_arb: a 4-producer/4-beat instance and a
// 3-producer/1-beat instance, checked cycle by cycle against hand values.
module tb_fifo_wr_rr_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid = '0;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        wr_en;
    logic [9:0]  fdata;
    logic        full = 1'b0;
    logic        busy;

    logic [2:0]  valid_b = '0;
    logic [23:0] data_b = {8'h22, 8'h21, 8'h20};
    logic [2:0]  ready_b;
    logic        wr_en_b;
    logic [9:0]  fdata_b;
    logic        busy_b;

    logic [7:0]  pay [4];
    logic [3:0]  prev_hold;
    logic [7:0]  prev_dat [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign data = {pay[3], pay[2], pay[1], pay[0]};

    fifo_wr_rr_arb #(.P_NUM_REQ(4), .P_DATA_W(8), .P_BURST(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (valid),
        .i_req_data   (data),
        .o_req_ready  (ready),
        .o_fifo_wr_en (wr_en),
        .o_fifo_data  (fdata),
        .i_fifo_full  (full),
        .o_busy       (busy)
    );

    fifo_wr_rr_arb #(.P_NUM_REQ(3), .P_DATA_W(8), .P_BURST(1)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (valid_b),
        .i_req_data   (data_b),
        .o_req_ready  (ready_b),
        .o_fifo_wr_en (wr_en_b),
        .o_fifo_data  (fdata_b),
        .i_fifo_full  (1'b0),
        .o_busy       (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One cycle on the main instance: drive at negedge, check 1ns later.
    task automatic cyc(input string tag, input logic [3:0] v, input logic f,
                       input logic exp_wr, input logic [1:0] exp_id, input logic exp_busy);
        @(negedge clk);
        valid = v;
        full  = f;
        for (int k = 0; k < 4; k++)
            if (prev_hold[k] && v[k]) chk({tag, "_hold"}, 32'(pay[k]), 32'(prev_dat[k]));
        #1;
        chk({tag, "_wr"}, 32'(wr_en), 32'(exp_wr));
        chk({tag, "_rdy"}, 32'(ready), exp_wr ? 32'(1) << exp_id : 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        if (exp_wr) chk({tag, "_data"}, 32'(fdata), 32'({exp_id, pay[exp_id]}));
        for (int k = 0; k < 4; k++) begin
            prev_hold[k] = v[k] && !ready[k];
            prev_dat[k]  = pay[k];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = '0;
        full  = 1'b0;
        prev_hold = '0;
        #1;
        chk("rst_wr", 32'(wr_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) pay[k] = 8'h10 + 8'(k);
        prev_hold = '0;

        // reset state with everyone requesting
        @(negedge clk);
        valid = 4'hF;
        #1;
        chk("reset_wr", 32'(wr_en), 32'(0));
        chk("reset_rdy", 32'(ready), 32'(0));
        chk("reset_data", 32'(fdata), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        do_reset();

        // 1: single producer 2, three beats then valid drops
        pay[2] = 8'hA1;
        cyc("t1_b1", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        pay[2] = 8'hA2;
        cyc("t1_b2", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
        pay[2] = 8'hA3;
        cyc("t1_b3", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
        cyc("t1_bub", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
        cyc("t1_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        pay[2] = 8'h12;

        // 2: all valid, four-beat grants rotating 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 17; i++)
            cyc($sformatf("t2_%0d", i), 4'hF, 1'b0, 1'b1, 2'((i / 4) % 4), (i % 4) != 0);

        // 3: producer 1 stalled by full mid-burst, then finishes and releases
        do_reset();
        cyc("t3_b1", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
        cyc("t3_b2", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("t3_full%0d", i), 4'hF, 1'b1, 1'b0, 2'd0, 1'b1);
        cyc("t3_b3", 4'hF, 1'b0, 1'b1, 2'd1, 1'b1);
        cyc("t3_b4", 4'hF, 1'b0, 1'b1, 2'd1, 1'b1);
        cyc("t3_next", 4'hF, 1'b0, 1'b1, 2'd2, 1'b0);

        // 4: producer 1 drops early; 3 then 0 follow after one bubble
        do_reset();
        cyc("t4_b1", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
        cyc("t4_b2", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
        cyc("t4_bub", 4'b1001, 1'b0, 1'b0, 2'd0, 1'b1);
        cyc("t4_g3", 4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);
        cyc("t4_g3b", 4'b1001, 1'b0, 1'b1, 2'd3, 1'b1);
        cyc("t4_g3c", 4'b1001, 1'b0, 1'b1, 2'd3, 1'b1);
        cyc("t4_g3d", 4'b1001, 1'b0, 1'b1, 2'd3, 1'b1);
        cyc("t4_g0", 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0);

        // 5: reset in the middle of producer 2's burst
        do_reset();
        cyc("t5_b1", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        cyc("t5_b2", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        valid = 4'hF;
        #1;
        chk("t5_rst_wr", 32'(wr_en), 32'(0));
        chk("t5_rst_rdy", 32'(ready), 32'(0));
        chk("t5_rst_data", 32'(fdata), 32'(0));
        chk("t5_rst_busy", 32'(busy), 32'(0));
        for (int k = 0; k < 4; k++) begin
            prev_hold[k] = 1'b1;
            prev_dat[k]  = pay[k];
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_after_wr", 32'(wr_en), 32'(1));
        chk("t5_after_rdy", 32'(ready), 32'(1));
        chk("t5_after_data", 32'(fdata), 32'({2'd0, pay[0]}));
        chk("t5_after_busy", 32'(busy), 32'(0));
        valid = '0;

        // 6: three producers, single-beat grants alternate every cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_b = 3'b111;
            #1;
            chk($sformatf("t6_wr%0d", i), 32'(wr_en_b), 32'(1));
            chk($sformatf("t6_rdy%0d", i), 32'(ready_b), 32'(1) << (i % 3));
            chk($sformatf("t6_data%0d", i), 32'(fdata_b), 32'({2'(i % 3), 8'(8'h20 + i % 3)}));
            chk($sformatf("t6_busy%0d", i), 32'(busy_b), 32'(0));
        end
        @(negedge clk);
        valid_b = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_rr_arb.md
Name: fifo_wr_rr_arb

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port among P_NUM_REQ producers. Each producer has a valid/ready beat interface. The block grants the FIFO to one producer at a time, for bursts of up to P_BURST beats, and tags each written word with the source ID. It sits directly in front of the FIFO write port: o_fifo_wr_en maps to i_wr_en, o_fifo_data to i_data, and i_fifo_full connects to o_full.

Parameters:
P_NUM_REQ, 4, number of producers (>=2)
P_DATA_W, 8, payload width per producer
P_BURST, 4, max consecutive beats per grant (>=1)
P_ID_W (localparam), $clog2(P_NUM_REQ), source-ID tag width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
i_req_valid  input  P_NUM_REQ  per-producer beat valid
i_req_data  input  P_NUM_REQ*P_DATA_W  producer k payload at bits [k*P_DATA_W +: P_DATA_W]
o_req_ready  output  P_NUM_REQ  per-producer beat accept (one-hot or zero)
o_fifo_wr_en  output  1  FIFO write enable
o_fifo_data  output  P_ID_W+P_DATA_W  {owner ID, owner payload}
i_fifo_full  input  1  FIFO full flag
o_busy  output  1  high while in BURST state

Behaviour:
- Beat transfer: producer k transfers a beat when i_req_valid[k] && o_req_ready[k]. o_fifo_wr_en equals OR of o_req_ready. Outputs are combinational from state and inputs, so there is zero added latency.
- Registered state:
  - FSM {IDLE, BURST}
  - owner ID
  - last-grant pointer lptr
  - burst counter cnt, 0..P_BURST
- IDLE:
  - Candidate = first valid requester scanning lptr+1, lptr+2, ... (mod P_NUM_REQ).
  - If a candidate exists and !i_fifo_full, ready[candidate]=1 and the beat transfers this cycle.
  - On transfer: owner<=cand, lptr<=cand. If P_BURST>1: cnt<=1, go to BURST. Otherwise stay in IDLE.
  - No candidate, or full: no transfer, state holds.
- BURST:
  - ready[owner] = i_req_valid[owner] && !i_fifo_full.
  - On transfer: cnt+1. If cnt+1==P_BURST, go to IDLE with cnt<=0.
  - Owner valid low: no transfer, go to IDLE next cycle. This costs exactly one bubble cycle, even if others are requesting.
  - i_fifo_full high: no transfer, cnt and owner held; the burst stays locked to the owner.
- Fairness: after a grant releases, the owner has lowest priority. No producer waits more than (P_NUM_REQ-1)*P_BURST beats plus bubbles once it asserts valid.
- Valid changes: a non-owner's valid may rise or fall at any time without effect. A producer must keep data stable while valid && !ready; this is a producer rule and is checked by the bench.
- Reset:
  - While rst_n is low, all outputs are forced to 0 combinationally.
  - Next edge: FSM=IDLE, cnt=0, owner=0, lptr=P_NUM_REQ-1, so producer 0 has first priority.
  - Reset mid-burst abandons the burst. The beat in the reset cycle is not written.
- Width rules:
  - cnt width is $clog2(P_BURST+1).
  - lptr/owner are P_ID_W bits. Wrap is explicit (==P_NUM_REQ-1 -> 0), correct for non-power-of-2 P_NUM_REQ.
  - P_ID_W uses max(1,...) so P_NUM_REQ=2 gives 1 bit.

Decomposition:
- Package fifo_arb_pkg: FSM state encoding constants (ST_IDLE, ST_BURST) and a clog2-based ID-width function with min 1.
- Sub-module rr_pri_enc: combinational rotating priority encoder. Inputs are the request vector and lptr; outputs are found and cand ID. It is reused by future read-side schedulers.

Test Plan:
1. Only producer 2 valid with payloads 0xA1,0xA2,0xA3, FIFO not full -> wr_en high 3 consecutive cycles from the first valid cycle; data {2,0xA1},{2,0xA2},{2,0xA3}; BURST exits to IDLE when valid drops; one bubble cycle.
2. All 4 valid continuously, P_BURST=4 -> owners 0,0,0,0,1,1,1,1,2×4,3×4,0...; o_busy low exactly one IDLE cycle per grant boundary, and that cycle still transfers.
3. Producer 1 owns the burst; after beat 2, full is held high 3 cycles -> wr_en=0 and ready=0 for 3 cycles, cnt held at 2; after full drops, beats 3 and 4 go to producer 1, then release.
4. Producer 1 drops valid after 2 beats while producers 0 and 3 are valid -> one bubble cycle, then producer 3 is granted (scan starts at 2), then producer 0.
5. Reset asserted mid-burst (producer 2, cnt=2) -> outputs 0 in the same cycle; after release with all valid, producer 0 is granted first.
6. P_BURST=1, P_NUM_REQ=3, all valid -> strict alternation 0,1,2,0,1,2 with wr_en high every cycle and o_busy never high.
